// File: rtl/cpu_pkg.sv
// Shared pipeline types and helpers for the CPU datapath stages.
package cpu_pkg;

  localparam int unsigned Xlen = 32;

  // Load/store width encodings in funct3
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} mem_state_e;

  typedef struct packed {
    logic            valid;
    logic [Xlen-1:0] pc;
    logic [Xlen-1:0] alu_result;
    logic [Xlen-1:0] rs2_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
  } ex_reg_d;

  typedef struct packed {
    logic            valid;
    logic [Xlen-1:0] pc;
    logic [4:0]      rd;
    logic            reg_write;
    logic [Xlen-1:0] result;
    logic            misaligned;
  } mem_reg_d;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word, 11 unchecked
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
    return ((size == 2'b01) && addr_lo[0]) || ((size == 2'b10) && (addr_lo != 2'b00));
  endfunction

  function automatic logic [3:0] store_be(logic [1:0] size, logic [1:0] addr_lo);
    logic [3:0] be;
    unique case (size)
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store data across lanes so byte enables alone select the target
  function automatic logic [Xlen-1:0] store_wdata(logic [1:0] size, logic [Xlen-1:0] rs2);
    logic [Xlen-1:0] wdata;
    unique case (size)
      2'b00:   wdata = {4{rs2[7:0]}};
      2'b01:   wdata = {2{rs2[15:0]}};
      default: wdata = rs2;
    endcase
    return wdata;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed byte/halfword and extends it.
module load_align
  import cpu_pkg::*;
(
  input  logic [Xlen-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [Xlen-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign/zero extension; unknown widths fall back to a word
  always_comb begin
    unique case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      result = {{(Xlen-8){byte_sel[7]}}, byte_sel};
      LBU:     result = {{(Xlen-8){1'b0}}, byte_sel};
      LH:      result = {{(Xlen-16){half_sel[15]}}, half_sel};
      LHU:     result = {{(Xlen-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores to data memory, aligns load data
// and drives the MEM/WB register, stalling EX while an access is outstanding.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  ex_reg_d            ex_in,
  output mem_reg_d           mem_out,
  output logic               stall,
  output logic               dmem_req_valid,
  input  logic               dmem_req_ready,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic               dmem_rsp_valid,
  input  logic [XLEN-1:0]    dmem_rdata
);

  mem_state_e state_q, state_d;
  mem_reg_d   mem_d;

  // Request fields held from issue until the access completes
  logic [Xlen-1:0] req_addr_q;
  logic [Xlen-1:0] req_wdata_q;
  logic [Xlen-1:0] req_pc_q;
  logic [3:0]      req_be_q;
  logic            req_load_q;
  logic [2:0]      req_funct3_q;
  logic [4:0]      req_rd_q;
  logic            req_reg_write_q;

  logic            ex_is_mem;
  logic            ex_is_load;
  logic            ex_misaligned;
  logic            ex_issue;
  logic [3:0]      ex_be;
  logic [Xlen-1:0] ex_wdata;

  logic            cur_load;
  logic [Xlen-1:0] cur_addr;
  logic [3:0]      cur_be;
  logic [Xlen-1:0] cur_wdata;
  logic [Xlen-1:0] load_result;

  // Decode the incoming EX bundle; a load wins when both mem_read and mem_write are set
  always_comb begin
    ex_is_mem     = ex_in.mem_read | ex_in.mem_write;
    ex_is_load    = ex_in.mem_read;
    ex_misaligned = is_misaligned(ex_in.funct3[1:0], ex_in.alu_result[1:0]);
    ex_issue      = (state_q == IDLE) & ex_in.valid & ex_is_mem & ~ex_misaligned;
    ex_be         = ex_is_load ? 4'b0000 : store_be(ex_in.funct3[1:0], ex_in.alu_result[1:0]);
    ex_wdata      = ex_is_load ? '0 : store_wdata(ex_in.funct3[1:0], ex_in.rs2_data);
  end

  // Request fields come straight from EX in IDLE, from the latches afterwards
  always_comb begin
    if (state_q == IDLE) begin
      cur_load  = ex_is_load;
      cur_addr  = ex_in.alu_result;
      cur_be    = ex_be;
      cur_wdata = ex_wdata;
    end else begin
      cur_load  = req_load_q;
      cur_addr  = req_addr_q;
      cur_be    = req_be_q;
      cur_wdata = req_wdata_q;
    end
  end

  assign dmem_we    = dmem_req_valid & ~cur_load;
  assign dmem_addr  = DMEM_AW'({cur_addr[Xlen-1:2], 2'b00});
  assign dmem_be    = cur_be;
  assign dmem_wdata = XLEN'(cur_wdata);

  load_align u_load_align (
    .rdata   (Xlen'(dmem_rdata)),
    .addr_lo (req_addr_q[1:0]),
    .funct3  (req_funct3_q),
    .result  (load_result)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ex_issue) begin
          if (!dmem_req_ready)  state_d = REQ;
          else if (ex_is_load)  state_d = WAIT_RSP;
        end
      end
      REQ: begin
        if (dmem_req_ready) state_d = req_load_q ? WAIT_RSP : IDLE;
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: request valid, stall and the next MEM/WB contents (bubble by default)
  always_comb begin
    dmem_req_valid = 1'b0;
    stall          = 1'b0;
    mem_d          = '0;
    unique case (state_q)
      IDLE: begin
        dmem_req_valid = ex_issue;
        // A store accepted immediately completes this cycle, so no hold is needed
        stall          = ex_issue & ~(dmem_req_ready & ~ex_is_load);
        if (ex_in.valid) begin
          mem_d.pc     = ex_in.pc;
          mem_d.rd     = ex_in.rd;
          mem_d.result = ex_in.alu_result;
          if (!ex_is_mem) begin
            mem_d.valid     = 1'b1;
            mem_d.reg_write = ex_in.reg_write;
          end else if (ex_misaligned) begin
            mem_d.valid      = 1'b1;
            mem_d.misaligned = 1'b1;
          end else if (dmem_req_ready && !ex_is_load) begin
            mem_d.valid = 1'b1;
          end
        end
      end
      REQ: begin
        dmem_req_valid = 1'b1;
        stall          = ~(dmem_req_ready & ~req_load_q);
        if (dmem_req_ready && !req_load_q) begin
          mem_d.valid  = 1'b1;
          mem_d.pc     = req_pc_q;
          mem_d.rd     = req_rd_q;
          mem_d.result = req_addr_q;
        end
      end
      WAIT_RSP: begin
        stall = ~dmem_rsp_valid;
        if (dmem_rsp_valid) begin
          mem_d.valid     = 1'b1;
          mem_d.pc        = req_pc_q;
          mem_d.rd        = req_rd_q;
          mem_d.reg_write = req_reg_write_q;
          mem_d.result    = load_result;
        end
      end
      default: ;
    endcase
  end

  // Capture request fields when a memory op is issued from IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      req_pc_q        <= '0;
      req_be_q        <= '0;
      req_load_q      <= 1'b0;
      req_funct3_q    <= '0;
      req_rd_q        <= '0;
      req_reg_write_q <= 1'b0;
    end else if (ex_issue) begin
      req_addr_q      <= ex_in.alu_result;
      req_wdata_q     <= ex_wdata;
      req_pc_q        <= ex_in.pc;
      req_be_q        <= ex_be;
      req_load_q      <= ex_is_load;
      req_funct3_q    <= ex_in.funct3;
      req_rd_q        <= ex_in.rd;
      req_reg_write_q <= ex_in.reg_write;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_out <= '0;
    end else begin
      mem_out <= mem_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// instruction stream scored against a byte-level memory model.
module tb_mem_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  ex_reg_d     ex_in;
  mem_reg_d    mem_out;
  logic        stall;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    mem_reg_d m;
    bit       chk_res;
  } exp_t;

  ex_reg_d     ops_q[$];
  exp_t        exp_q[$];
  logic [31:0] model_mem [64];
  logic [31:0] phys_mem  [64];
  int          n_loads;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32), .DMEM_AW(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_in          (ex_in),
    .mem_out        (mem_out),
    .stall          (stall),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata)
  );

  function automatic ex_reg_d mk(logic [31:0] pc, logic [31:0] alu, logic [31:0] rs2,
                                 logic [4:0] rd, logic rw, logic mr, logic mw, logic [2:0] f3);
    ex_reg_d e;
    e.valid = 1'b1; e.pc = pc; e.alu_result = alu; e.rs2_data = rs2; e.rd = rd;
    e.reg_write = rw; e.mem_read = mr; e.mem_write = mw; e.funct3 = f3;
    return e;
  endfunction

  // Reference: pick the addressed bytes arithmetically and extend them
  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] lo, logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hff;
    h = (w >> (16 * lo[1])) & 32'hffff;
    case (f3)
      3'b000:  return (b >= 128) ? (b | 32'hffff_ff00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? (h | 32'hffff_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_mis(logic [2:0] f3, logic [1:0] lo);
    return (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
  endfunction

  task automatic init_mem;
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = $urandom();
      phys_mem[i]  = model_mem[i];
    end
  endtask

  // Queue an instruction for the stream and record its expected MEM/WB outcome
  task automatic queue_op(input ex_reg_d op);
    exp_t e;
    int   idx, first, nb;
    ops_q.push_back(op);
    if (!op.valid) return;
    e.m = '0; e.m.valid = 1'b1; e.m.pc = op.pc; e.m.rd = op.rd; e.chk_res = 1'b0;
    idx = int'(op.alu_result[7:2]);
    if (!(op.mem_read || op.mem_write)) begin
      e.m.reg_write = op.reg_write; e.m.result = op.alu_result; e.chk_res = 1'b1;
    end else if (ref_mis(op.funct3, op.alu_result[1:0])) begin
      e.m.misaligned = 1'b1;
    end else if (op.mem_read) begin
      e.m.reg_write = op.reg_write;
      e.m.result    = ref_load(model_mem[idx], op.alu_result[1:0], op.funct3);
      e.chk_res     = 1'b1;
      n_loads++;
    end else begin
      case (op.funct3[1:0])
        2'b00:   begin first = int'(op.alu_result[1:0]); nb = 1; end
        2'b01:   begin first = int'(op.alu_result[1:0]) & 2; nb = 2; end
        default: begin first = 0; nb = 4; end
      endcase
      for (int k = 0; k < nb; k++) model_mem[idx][8*(first+k) +: 8] = op.rs2_data[8*k +: 8];
    end
    exp_q.push_back(e);
  endtask

  function automatic ex_reg_d rand_op();
    ex_reg_d o;
    int k;
    logic [31:0] a;
    o = '0; o.valid = 1'b1; o.pc = $urandom(); o.rd = 5'($urandom());
    o.rs2_data = $urandom(); o.reg_write = 1'($urandom());
    a = $urandom_range(0, 255);
    k = $urandom_range(0, 9);
    if (k < 2) begin
      o.alu_result = $urandom();
    end else if (k < 5) begin
      o.mem_read = 1'b1; o.mem_write = ($urandom_range(0, 7) == 0);
      o.funct3 = 3'($urandom());
      if ($urandom_range(0, 9) < 7) a = a & ~32'h3;
      o.alu_result = a;
    end else if (k < 8) begin
      o.mem_write = 1'b1; o.funct3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 7) a = a & ~32'h3;
      o.alu_result = a;
    end else begin
      o.valid = 1'b0;
    end
    return o;
  endfunction

  // Drive the queued stream as an EX register would (advance only when not stalled),
  // act as data memory, and score every MEM/WB output in order.
  task automatic run_stream(input bit rnd, output int stall_cycles);
    bit   pend, fire, hs;
    int   cnt, pidx;
    exp_t e;
    pend = 1'b0; cnt = 0; pidx = 0; stall_cycles = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (ops_q.size() == 0 && exp_q.size() == 0 && !pend) break;
      if (ops_q.size() != 0) ex_in = ops_q[0]; else ex_in = '0;
      dmem_req_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      fire = pend && (cnt == 0);
      dmem_rsp_valid = fire;
      dmem_rdata = fire ? phys_mem[pidx] : $urandom();
      #4;
      if (stall) stall_cycles++;
      hs = dmem_req_valid && dmem_req_ready;
      if (hs) begin
        n_checks++;
        if (pend || dmem_addr[31:8] != 24'h0 || dmem_addr[1:0] != 2'b00)
          $display("FAIL stream_issue: addr=%h outstanding=%0b, want aligned addr <0x100, none outstanding",
                   dmem_addr, pend);
        else n_pass++;
        if (dmem_we) begin
          for (int k = 0; k < 4; k++)
            if (dmem_be[k]) phys_mem[dmem_addr[7:2]][8*k +: 8] = dmem_wdata[8*k +: 8];
        end else begin
          pend = 1'b1; pidx = int'(dmem_addr[7:2]);
          cnt = rnd ? $urandom_range(0, 3) : 1;
        end
      end
      if (fire) pend = 1'b0;
      else if (pend && !(hs && !dmem_we) && cnt > 0) cnt--;
      if (!stall && ops_q.size() != 0) void'(ops_q.pop_front());
      @(posedge clk); #1;
      if (mem_out.valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL stream_extra: unexpected output pc=%h rd=%0d", mem_out.pc, mem_out.rd);
        end else begin
          e = exp_q.pop_front();
          if (mem_out.pc !== e.m.pc || mem_out.rd !== e.m.rd ||
              mem_out.reg_write !== e.m.reg_write || mem_out.misaligned !== e.m.misaligned ||
              (e.chk_res && mem_out.result !== e.m.result))
            $display("FAIL stream_out: got pc=%h rd=%0d rw=%0b mis=%0b res=%h want pc=%h rd=%0d rw=%0b mis=%0b res=%h",
                     mem_out.pc, mem_out.rd, mem_out.reg_write, mem_out.misaligned, mem_out.result,
                     e.m.pc, e.m.rd, e.m.reg_write, e.m.misaligned, e.m.result);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (ops_q.size() != 0 || exp_q.size() != 0)
      $display("FAIL stream_drain: ops left=%0d outputs missing=%0d, want 0/0", ops_q.size(), exp_q.size());
    else n_pass++;
    ops_q.delete(); exp_q.delete();
    ex_in = '0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; ex_in = '0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (mem_out !== '0 || dmem_req_valid !== 1'b0 || stall !== 1'b0)
      $display("FAIL reset_state: mem_out=%h req_valid=%b stall=%b, want all zero", mem_out, dmem_req_valid, stall);
    else n_pass++;
    reset = 1'b1;
    ex_in = mk(32'h100, 32'h40, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, LW);
    dmem_req_ready = 1'b1;
    #4;
    n_checks++;
    if (dmem_req_valid !== 1'b1 || stall !== 1'b1)
      $display("FAIL reset_issue: req_valid=%b stall=%b, want 1 1", dmem_req_valid, stall);
    else n_pass++;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    #4;
    n_checks++;
    if (dmem_req_valid !== 1'b0 || stall !== 1'b1)
      $display("FAIL reset_wait: req_valid=%b stall=%b, want 0 1", dmem_req_valid, stall);
    else n_pass++;
    #2; reset = 1'b0; ex_in = '0;
    #1;
    n_checks++;
    if (mem_out.valid !== 1'b0 || stall !== 1'b0)
      $display("FAIL reset_async: valid=%b stall=%b, want 0 0", mem_out.valid, stall);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hdead_beef;
    #4;
    n_checks++;
    if (stall !== 1'b0 || dmem_req_valid !== 1'b0)
      $display("FAIL reset_rsp_comb: stall=%b req_valid=%b, want 0 0", stall, dmem_req_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (mem_out.valid !== 1'b0)
      $display("FAIL reset_rsp_ignored: valid=%b, want 0", mem_out.valid);
    else n_pass++;
    dmem_rsp_valid = 1'b0;
  endtask

  task automatic test_alu;
    ex_in = mk(32'h400, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    #4;
    n_checks++;
    if (dmem_req_valid !== 1'b0 || stall !== 1'b0)
      $display("FAIL alu_comb: req_valid=%b stall=%b, want 0 0", dmem_req_valid, stall);
    else n_pass++;
    @(posedge clk); #1;
    ex_in = '0;
    n_checks++;
    if (mem_out.valid !== 1'b1 || mem_out.rd !== 5'd5 || mem_out.result !== 32'h1234 ||
        mem_out.reg_write !== 1'b1 || mem_out.misaligned !== 1'b0)
      $display("FAIL alu_out: valid=%b rd=%0d res=%h rw=%b, want 1 5 00001234 1",
               mem_out.valid, mem_out.rd, mem_out.result, mem_out.reg_write);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (mem_out.valid !== 1'b0)
      $display("FAIL alu_bubble: valid=%b, want 0", mem_out.valid);
    else n_pass++;
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] want);
    int stalls;
    stalls = 0;
    ex_in = mk(32'h200, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, f3);
    dmem_req_ready = 1'b1;
    #4;
    n_checks++;
    if (dmem_req_valid !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b0000 || dmem_we !== 1'b0)
      $display("FAIL load_req: valid=%b addr=%h be=%b we=%b, want 1 00000100 0000 0",
               dmem_req_valid, dmem_addr, dmem_be, dmem_we);
    else n_pass++;
    if (stall) stalls++;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #4;
      n_checks++;
      if (dmem_req_valid !== 1'b0)
        $display("FAIL load_wait_req: req_valid=%b, want 0", dmem_req_valid);
      else n_pass++;
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h80ff_0000;
    #4;
    if (stall) stalls++;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0; ex_in = '0;
    n_checks++;
    if (mem_out.valid !== 1'b1 || mem_out.rd !== 5'd7 || mem_out.result !== want || mem_out.reg_write !== 1'b1)
      $display("FAIL load_out f3=%0d: valid=%b rd=%0d res=%h, want 1 7 %h", f3, mem_out.valid,
               mem_out.rd, mem_out.result, want);
    else n_pass++;
    n_checks++;
    if (stalls != 3) $display("FAIL load_stall_cycles: got %0d want 3", stalls);
    else n_pass++;
  endtask

  task automatic test_store_backpressure;
    ex_in = mk(32'h300, 32'h202, 32'haaaa_beef, 5'd0, 1'b0, 1'b0, 1'b1, SH);
    for (int i = 0; i < 4; i++) begin
      dmem_req_ready = (i == 3);
      #4;
      n_checks++;
      if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200 ||
          dmem_be !== 4'b1100 || dmem_wdata !== 32'hbeef_beef)
        $display("FAIL store_req cyc%0d: valid=%b we=%b addr=%h be=%b wdata=%h, want 1 1 00000200 1100 beefbeef",
                 i, dmem_req_valid, dmem_we, dmem_addr, dmem_be, dmem_wdata);
      else n_pass++;
      n_checks++;
      if (stall !== (i < 3))
        $display("FAIL store_stall cyc%0d: got %b want %b", i, stall, (i < 3));
      else n_pass++;
      @(posedge clk); #1;
      // Held request must come from the captured fields, not the live EX bundle
      if (i == 0) begin ex_in.alu_result = 32'h777; ex_in.rs2_data = 32'h0; end
    end
    ex_in = '0; dmem_req_ready = 1'b0;
    n_checks++;
    if (mem_out.valid !== 1'b1 || mem_out.reg_write !== 1'b0 || mem_out.misaligned !== 1'b0)
      $display("FAIL store_out: valid=%b rw=%b mis=%b, want 1 0 0", mem_out.valid, mem_out.reg_write,
               mem_out.misaligned);
    else n_pass++;
    #4;
    n_checks++;
    if (dmem_req_valid !== 1'b0) $display("FAIL store_done: req_valid=%b, want 0", dmem_req_valid);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned;
    ex_reg_d ops [2];
    ops[0] = mk(32'h500, 32'h301, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, LW);
    ops[1] = mk(32'h504, 32'h203, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b1, SH);
    dmem_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ex_in = ops[i];
      #4;
      n_checks++;
      if (dmem_req_valid !== 1'b0 || stall !== 1'b0)
        $display("FAIL mis_comb%0d: req_valid=%b stall=%b, want 0 0", i, dmem_req_valid, stall);
      else n_pass++;
      @(posedge clk); #1;
      ex_in = '0;
      n_checks++;
      if (mem_out.valid !== 1'b1 || mem_out.misaligned !== 1'b1 || mem_out.reg_write !== 1'b0)
        $display("FAIL mis_out%0d: valid=%b mis=%b rw=%b, want 1 1 0", i, mem_out.valid,
                 mem_out.misaligned, mem_out.reg_write);
      else n_pass++;
    end
    dmem_req_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int stalls;
    init_mem();
    n_loads = 0;
    queue_op(mk(32'h600, 32'h10, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, LW));
    queue_op(mk(32'h604, 32'h14, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, LW));
    queue_op(mk(32'h608, 32'h99, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000));
    run_stream(1'b0, stalls);
    n_checks++;
    if (stalls != 4) $display("FAIL b2b_stalls: got %0d want 4", stalls);
    else n_pass++;
    // Mixed stream, always-ready memory: only loads cost stall cycles
    n_loads = 0;
    for (int i = 0; i < 30; i++) queue_op(rand_op());
    run_stream(1'b0, stalls);
    n_checks++;
    if (stalls != 2 * n_loads) $display("FAIL mix_stalls: got %0d want %0d", stalls, 2 * n_loads);
    else n_pass++;
  endtask

  task automatic test_random;
    int stalls;
    init_mem();
    n_loads = 0;
    for (int i = 0; i < 200; i++) queue_op(rand_op());
    run_stream(1'b1, stalls);
    n_checks++;
    if (model_mem != phys_mem) $display("FAIL random_memory: memory image differs from model");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte(LB, 32'hffff_ff80);
    test_load_byte(LBU, 32'h0000_0080);
    test_store_backpressure();
    test_misaligned();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
